// File: rtl/ledsuit_pkg.sv
// Shared types and timing defaults for the LED-suit strip datapath.
// Frame and latch defaults are derived from the board clock and refresh rate.
package ledsuit_pkg;

    localparam int CLK_HZ   = 16_000_000;
    localparam int FPS      = 60;
    localparam int LATCH_US = 100;
    localparam int PIX_W    = 24;

    // Rounded to the nearest cycle so 16 MHz / 60 Hz gives 266667
    localparam int FRAME_CYCLES_DEF = (CLK_HZ + FPS / 2) / FPS;
    localparam int LATCH_CYCLES_DEF = (CLK_HZ / 1_000_000) * LATCH_US;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_WAIT    = 3'd2,
        S_PRESENT = 3'd3,
        S_DRAIN   = 3'd4,
        S_LATCH   = 3'd5,
        S_HOLD    = 3'd6
    } seq_state_e;

    function automatic logic is_frame_active(input seq_state_e s);
        return (s != S_IDLE) && (s != S_HOLD);
    endfunction

endpackage

// File: rtl/frame_rate_timer.sv
// Free-running frame-rate counter; tick is high on the wrap cycle.
// Runs independently of any enable so frame cadence never drifts.
module frame_rate_timer
    import ledsuit_pkg::*;
#(
    parameter int FRAME_CYCLES = FRAME_CYCLES_DEF
) (
    input  logic CLK,
    input  logic rst,
    output logic tick
);

    localparam int CNT_W = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Wrap detection and next count
    always_comb begin
        tick  = (cnt_q == CNT_LAST);
        cnt_d = tick ? '0 : cnt_q + CNT_W'(1'b1);
    end

    // Counter register
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/strip_frame_sequencer.sv
// Walks pixel RAM once per frame, hands words to the strip serializer,
// then enforces the strip latch gap before waiting for the next frame tick.
module strip_frame_sequencer #(
    parameter int ADDR_W       = 13,
    parameter int PIX_W        = ledsuit_pkg::PIX_W,
    parameter int LEN_W        = 10,
    parameter int LATCH_CYCLES = ledsuit_pkg::LATCH_CYCLES_DEF,
    parameter int FRAME_CYCLES = ledsuit_pkg::FRAME_CYCLES_DEF
) (
    input  logic              CLK,
    input  logic              rst,
    input  logic              enable,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  num_leds,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [PIX_W-1:0]  mem_rdata,
    output logic [PIX_W-1:0]  pix_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    input  logic              ser_busy,
    output logic              frame_start,
    output logic              frame_done,
    output logic              overrun,
    output logic              busy
);
    import ledsuit_pkg::*;

    // The DRAIN cycle that sees ser_busy low is the first idle cycle of the gap
    localparam int LATCH_W = (LATCH_CYCLES > 2) ? $clog2(LATCH_CYCLES) : 1;
    localparam logic [LATCH_W-1:0] LATCH_LAST = LATCH_W'(LATCH_CYCLES - 2);

    seq_state_e        state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [LEN_W-1:0]  num_q, num_d;
    logic [LEN_W-1:0]  index_q, index_d;
    logic [LATCH_W-1:0] latch_cnt_q, latch_cnt_d;
    logic              pending_q, pending_d;
    logic              enable_q;
    logic              overrun_q, overrun_d;
    logic [PIX_W-1:0]  pix_data_q, pix_data_d;
    logic              pix_valid_q, pix_valid_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_rd_en_q, mem_rd_en_d;
    logic              frame_start_q, frame_start_d;
    logic              frame_done_q, frame_done_d;
    logic              busy_q, busy_d;
    logic              tick_s;
    logic              rise_s;
    logic              start_s;

    frame_rate_timer #(
        .FRAME_CYCLES (FRAME_CYCLES)
    ) u_frame_rate_timer (
        .CLK  (CLK),
        .rst  (rst),
        .tick (tick_s)
    );

    // Frame sequencing, pixel datapath and registered outputs
    always_comb begin
        state_d       = state_q;
        base_d        = base_q;
        num_d         = num_q;
        index_d       = index_q;
        latch_cnt_d   = latch_cnt_q;
        pending_d     = pending_q;
        overrun_d     = overrun_q;
        pix_data_d    = pix_data_q;
        pix_valid_d   = pix_valid_q;
        frame_start_d = 1'b0;
        frame_done_d  = 1'b0;
        start_s       = 1'b0;
        rise_s        = enable & ~enable_q;

        if (tick_s && is_frame_active(state_q)) begin
            overrun_d = 1'b1;
            pending_d = 1'b1;
        end else begin
            overrun_d = overrun_q;
        end

        case (state_q)
            S_IDLE: start_s = enable & (tick_s | rise_s);
            S_HOLD: begin
                if (enable) begin
                    start_s = tick_s | pending_q;
                end else begin
                    state_d   = S_IDLE;
                    pending_d = 1'b0;
                end
            end
            S_FETCH: state_d = S_WAIT;
            S_WAIT: begin
                pix_data_d  = mem_rdata;
                pix_valid_d = 1'b1;
                state_d     = S_PRESENT;
            end
            S_PRESENT: begin
                if (pix_ready) begin
                    pix_valid_d = 1'b0;
                    if (index_q == num_q - LEN_W'(1'b1)) begin
                        state_d = S_DRAIN;
                    end else begin
                        index_d = index_q + LEN_W'(1'b1);
                        state_d = S_FETCH;
                    end
                end else begin
                    pix_valid_d = 1'b1;
                end
            end
            S_DRAIN: begin
                if (!ser_busy) begin
                    latch_cnt_d = '0;
                    state_d     = S_LATCH;
                end else begin
                    latch_cnt_d = latch_cnt_q;
                end
            end
            S_LATCH: begin
                latch_cnt_d = latch_cnt_q + LATCH_W'(1'b1);
                if (latch_cnt_q == LATCH_LAST) begin
                    frame_done_d = 1'b1;
                    state_d      = S_HOLD;
                end else begin
                    state_d = S_LATCH;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (start_s) begin
            base_d        = base_addr;
            num_d         = num_leds;
            index_d       = '0;
            pending_d     = 1'b0;
            frame_start_d = 1'b1;
            state_d       = (num_leds == '0) ? S_HOLD : S_FETCH;
        end else begin
            base_d = base_q;
        end

        // An empty frame reports completion one cycle after its start pulse
        if (frame_start_q && (num_q == '0)) begin
            frame_done_d = 1'b1;
        end else begin
            pending_d = pending_d;
        end

        mem_rd_en_d = (state_d == S_FETCH);
        mem_addr_d  = mem_rd_en_d ? (base_d + ADDR_W'(index_d)) : mem_addr_q;
        busy_d      = is_frame_active(state_d);
    end

    // State and output registers
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            base_q        <= '0;
            num_q         <= '0;
            index_q       <= '0;
            latch_cnt_q   <= '0;
            pending_q     <= 1'b0;
            enable_q      <= 1'b0;
            overrun_q     <= 1'b0;
            pix_data_q    <= '0;
            pix_valid_q   <= 1'b0;
            mem_addr_q    <= '0;
            mem_rd_en_q   <= 1'b0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            base_q        <= base_d;
            num_q         <= num_d;
            index_q       <= index_d;
            latch_cnt_q   <= latch_cnt_d;
            pending_q     <= pending_d;
            enable_q      <= enable;
            overrun_q     <= overrun_d;
            pix_data_q    <= pix_data_d;
            pix_valid_q   <= pix_valid_d;
            mem_addr_q    <= mem_addr_d;
            mem_rd_en_q   <= mem_rd_en_d;
            frame_start_q <= frame_start_d;
            frame_done_q  <= frame_done_d;
            busy_q        <= busy_d;
        end
    end

    assign mem_addr    = mem_addr_q;
    assign mem_rd_en   = mem_rd_en_q;
    assign pix_data    = pix_data_q;
    assign pix_valid   = pix_valid_q;
    assign frame_start = frame_start_q;
    assign frame_done  = frame_done_q;
    assign overrun     = overrun_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_strip_frame_sequencer.sv
// Directed-plus-random bench for strip_frame_sequencer with a RAM model,
// a serializer model and a per-frame reference of expected reads and pixels.
module tb_strip_frame_sequencer;

    localparam int LATCH = 16;
    localparam int FRAME = 2000;

    logic        CLK = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [12:0] base_addr = '0;
    logic [9:0]  num_leds = '0;
    logic [12:0] mem_addr;
    logic        mem_rd_en;
    logic [23:0] mem_rdata = '0;
    logic [23:0] pix_data;
    logic        pix_valid;
    logic        pix_ready = 1'b0;
    logic        ser_busy = 1'b0;
    logic        frame_start;
    logic        frame_done;
    logic        overrun;
    logic        busy;

    strip_frame_sequencer #(
        .ADDR_W(13), .PIX_W(24), .LEN_W(10),
        .LATCH_CYCLES(LATCH), .FRAME_CYCLES(FRAME)
    ) dut (
        .CLK(CLK), .rst(rst), .enable(enable),
        .base_addr(base_addr), .num_leds(num_leds),
        .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .ser_busy(ser_busy), .frame_start(frame_start), .frame_done(frame_done),
        .overrun(overrun), .busy(busy)
    );

    always #5 CLK = ~CLK;

    logic [23:0] ram [0:8191];
    logic [12:0] rd_q [$];
    logic [23:0] rx [$];
    int tests = 0, fails = 0;
    int cyc = 0, ser_cnt = 0, ser_len = 4;
    bit ready_always = 1'b0;
    int stall_idx = -1, stall_left = 0, stall_total = 0, unstable = 0, rd_in_stall = 0;
    logic [23:0] stall_word = '0;
    bit rd_pend = 1'b0;
    logic [12:0] rd_addr_pend = '0;
    int start_cnt = 0, done_cnt = 0, start_cyc = 0, done_cyc = 0, fall_cyc = 0;

    // RAM, serializer and event monitor, all evaluated on the falling edge
    always @(negedge CLK) begin
        bit prev_busy;
        bit stalling;
        cyc++;
        if (rst) begin
            ser_cnt = 0; ser_busy = 1'b0; pix_ready = 1'b0; rd_pend = 1'b0;
        end else begin
            mem_rdata = rd_pend ? ram[rd_addr_pend] : 24'($urandom);
            rd_pend = mem_rd_en;
            rd_addr_pend = mem_addr;
            stalling = (stall_left > 0) && (rx.size() == stall_idx) && pix_valid;
            if (mem_rd_en) begin
                rd_q.push_back(mem_addr);
                if (stalling) rd_in_stall++;
            end
            if (frame_start) begin start_cnt++; start_cyc = cyc; end
            if (frame_done) begin done_cnt++; done_cyc = cyc; end
            if (ser_cnt > 0) ser_cnt--;
            prev_busy = ser_busy;
            ser_busy = (ser_cnt != 0);
            if (prev_busy && !ser_busy) fall_cyc = cyc;
            if (stalling) begin
                if (stall_left == stall_total) stall_word = pix_data;
                else if (pix_data !== stall_word) unstable++;
                stall_left--;
            end
            pix_ready = !stalling && (ready_always || !ser_busy);
            if (pix_valid && pix_ready) begin
                rx.push_back(pix_data);
                ser_cnt = ser_len;
                ser_busy = (ser_len != 0);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge CLK);
        #1;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!frame_done && n < budget) begin step(); n++; end
        chk("done_timeout", 32'(frame_done), 32'd1);
    endtask

    // Reference: pixel i of a frame is read from (base + i) mod 2^13
    task automatic check_frame(input int base, input int num);
        chk("rd_count", rd_q.size(), num);
        chk("pix_count", rx.size(), num);
        for (int i = 0; i < rd_q.size() && i < num; i++)
            chk("rd_addr", 32'(rd_q[i]), (base + i) % 8192);
        for (int i = 0; i < rx.size() && i < num; i++)
            chk("pix_data", 32'(rx[i]), 32'(ram[(base + i) % 8192]));
        if (num > 0) chk("latch_gap", done_cyc - fall_cyc, LATCH);
    endtask

    task automatic setup_frame(input int base, input int num, input int len, input bit ra);
        enable = 1'b0;
        repeat (3) step();
        rd_q.delete();
        rx.delete();
        base_addr = 13'(base);
        num_leds = 10'(num);
        ser_len = len;
        ready_always = ra;
    endtask

    task automatic run_frame(input int base, input int num, input int len, input bit ra);
        int s0;
        setup_frame(base, num, len, ra);
        s0 = start_cnt;
        enable = 1'b1;
        wait_done(num * 80 + 200);
        enable = 1'b0;
        chk("frame_start_count", start_cnt - s0, 1);
        check_frame(base, num);
    endtask

    initial begin
        int b, s0, d, n;
        for (int i = 0; i < 8192; i++) ram[i] = 24'($urandom);

        repeat (4) step();
        chk("rst_pix_valid", 32'(pix_valid), 32'd0);
        chk("rst_mem_rd_en", 32'(mem_rd_en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_frame_start", 32'(frame_start), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_pix_data", 32'(pix_data), 32'd0);
        rst = 1'b0;

        run_frame(32'h010, 3, 5, 1'b1);
        chk("no_overrun_short", 32'(overrun), 32'd0);

        run_frame(32'h1FFE, 4, 3, 1'b0);

        for (int k = 0; k < 3; k++)
            run_frame(int'($urandom_range(0, 8191)), int'($urandom_range(1, 8)),
                      int'($urandom_range(2, 8)), 1'b0);

        // Backpressure on the third pixel
        stall_idx = 2; stall_total = 50; stall_left = 50; unstable = 0; rd_in_stall = 0;
        run_frame(int'($urandom_range(0, 8191)), 3, 3, 1'b0);
        chk("stall_len", stall_left, 0);
        chk("stall_stable", unstable, 0);
        chk("stall_no_reads", rd_in_stall, 0);
        stall_idx = -1;

        // Empty frame
        setup_frame(100, 0, 3, 1'b0);
        s0 = start_cnt;
        enable = 1'b1;
        wait_done(50);
        enable = 1'b0;
        chk("zero_start", start_cnt - s0, 1);
        chk("zero_done_lat", done_cyc - start_cyc, 1);
        chk("zero_reads", rd_q.size(), 0);

        // Long frame overruns the tick; the pending tick restarts immediately
        b = int'($urandom_range(0, 8191));
        setup_frame(b, 400, 30, 1'b0);
        s0 = start_cnt;
        enable = 1'b1;
        n = 0;
        while (start_cnt == s0 && n < 20) begin step(); n++; end
        chk("long_start", start_cnt - s0, 1);
        num_leds = 10'd2;
        wait_done(30000);
        check_frame(b, 400);
        chk("overrun", 32'(overrun), 32'd1);
        d = done_cyc;
        n = 0;
        while (!frame_start && n < 20) begin step(); n++; end
        chk("pending_restart", start_cyc - d, 1);
        enable = 1'b0;
        wait_done(1000);

        // Enable dropped after the first pixel: frame completes, no restart
        b = int'($urandom_range(0, 8191));
        setup_frame(b, 3, 4, 1'b0);
        s0 = start_cnt;
        enable = 1'b1;
        n = 0;
        while (rx.size() < 1 && n < 200) begin step(); n++; end
        enable = 1'b0;
        wait_done(2000);
        check_frame(b, 3);
        repeat (FRAME + 100) step();
        chk("no_restart", start_cnt - s0, 1);
        chk("idle_busy", 32'(busy), 32'd0);

        // Reset while a pixel is presented
        b = int'($urandom_range(0, 8191));
        setup_frame(b, 5, 4, 1'b0);
        enable = 1'b1;
        n = 0;
        while (!pix_valid && n < 50) begin step(); n++; end
        rst = 1'b1;
        #1;
        chk("rst_mid_pix_valid", 32'(pix_valid), 32'd0);
        chk("rst_mid_mem_rd_en", 32'(mem_rd_en), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_overrun", 32'(overrun), 32'd0);
        step();
        step();
        rd_q.delete();
        rx.delete();
        s0 = start_cnt;
        rst = 1'b0;
        wait_done(2000);
        enable = 1'b0;
        chk("restart_after_rst", start_cnt - s0, 1);
        check_frame(b, 5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
